mbist_repair_mux: RTL
=====================

MBIST_REPAIR_MUX -- requirements
Module: mbist_repair_mux

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- BIST_ADDR_WD, 9, address width.
- BIST_DATA_WD, 32, data width (multiple of 8).
- BIST_REPAIR_CNT, 4, number of repair entries (1..16).
- BIST_REPAIR_ADDR_START, 9'h1F8, first spare-row address.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, sync active-high reset.
- bist_en, in, 1, BIST owns memory.
- bist_addr, in, BIST_ADDR_WD, BIST address.
- bist_wdata, in, BIST_DATA_WD, BIST write data.
- bist_wr / bist_rd, in, 1 each, BIST write/read strobe.
- bist_error, in, 1, failing location reported.
- bist_error_addr, in, BIST_ADDR_WD, failing address.
- bist_correct, out, 1, all errors so far repairable.
- bist_repair_full, out, 1, all entries used.
- bist_shift / bist_sdi, in, 1 each, repair-table scan shift/data.
- bist_sdo, out, 1, scan out.
- func_cen / func_web, in, 1 each, functional chip-enable/write-enable (active-low).
- func_mask, in, BIST_DATA_WD/8, byte mask.
- func_addr, in, BIST_ADDR_WD, functional address.
- func_din, in, BIST_DATA_WD, functional write data.
- func_dout, out, BIST_DATA_WD, read data.
- mem_cen / mem_web, out, 1 each, to macro.
- mem_mask, out, BIST_DATA_WD/8, to macro.
- mem_addr, out, BIST_ADDR_WD, to macro.
- mem_din, out, BIST_DATA_WD, to macro.
- mem_dout, in, BIST_DATA_WD, from macro.

Function
REQ-004 Source select SHALL work as follows: bist_en=1 selects the BIST path; 0 selects the functional path.
REQ-005 BIST path encoding SHALL be: cen = !(bist_rd|bist_wr); web = !bist_wr; mask = all ones; din = bist_wdata.
REQ-006 All mem_* outputs SHALL be registered, one cycle latency from inputs. func_dout SHALL equal mem_dout combinationally.
REQ-007 The repair table SHALL hold BIST_REPAIR_CNT entries, each {valid, addr[BIST_ADDR_WD-1:0]}.
REQ-008 Remap: if the selected address matches a valid entry i (lowest i wins), the registered mem_addr SHALL be BIST_REPAIR_ADDR_START+i; otherwise the address SHALL pass through. Remap SHALL apply in both modes.
REQ-009 Capture: on bist_error with bist_shift=0, the block SHALL act as follows:
- error address already valid in the table: no change.
- else, a free entry exists: write the lowest invalid entry {1, bist_error_addr}.
- else: clear bist_correct (sticky until rst).
REQ-010 A capture SHALL take effect at the next clock edge. An access in the same cycle as its own error SHALL use the pre-update table.
REQ-011 bist_repair_full SHALL be 1 when every entry is valid; it SHALL be registered, consistent with the table in the same cycle.
REQ-012 With bist_shift=1, the table SHALL shift one bit per clock.
- chain is entry[CNT-1]..entry[0], each {valid, addr}, chain length CNT*(BIST_ADDR_WD+1).
- bist_sdi enters entry[0] bit 0.
- bist_sdo SHALL be the MSB (valid) of entry[CNT-1].
REQ-013 Shift SHALL have priority over capture; bist_error SHALL be ignored while shifting.
REQ-014 bist_correct SHALL NOT be modified by shift.
REQ-015 Addresses SHALL be compared at full BIST_ADDR_WD. The sum BIST_REPAIR_ADDR_START+i SHALL be truncated to BIST_ADDR_WD.

Reset
REQ-016 On rst=1 at a clock edge, the block SHALL reset as follows:
- all entries invalid, addr 0.
- bist_correct=1, bist_repair_full=0, bist_sdo=0.
- mem_cen=1, mem_web=1, mem_mask=0, mem_addr=0, mem_din=0.
REQ-017 Reset mid-shift or mid-capture SHALL discard the operation; there SHALL be no partial update.

Configuration
REQ-018 Macro MBIST_REPAIR_SCAN_EN SHALL control the scan feature:
- defined: scan per REQ-012..014.
- undefined: bist_shift and bist_sdi ignored, bist_sdo tied 0, no chain logic; capture behaviour unchanged.

Verification
REQ-019 The bench SHALL cover these scenarios (defaults, CNT=4):
- rst, bist_en=0, func_addr=9'h010, func_cen=0, func_web=0 -> next cycle mem_addr=9'h010, mem_web=0, mem_mask=func_mask.
- bist_en=1, bist_error with addr 9'h020, then bist_rd at 9'h020 -> mem_addr=9'h1F8, mem_cen=0, mem_web=1, mem_mask=4'hF.
- errors 9'h001..9'h004, then a repeat of 9'h002 -> bist_repair_full=1, bist_correct=1; a 5th new error 9'h005 -> bist_correct=0 until rst.
- error on 9'h030 and bist_rd 9'h030 in the same cycle -> mem_addr=9'h030; next access -> 9'h1F8.
- with MBIST_REPAIR_SCAN_EN, entry0={1,9'h0AA}, shift 40 clocks with sdi=0 -> sdo serialises entries 3..0 MSB-first, ending with 1,0_1010_1010. Shift the pattern back in -> remap restored.
- rst asserted during the 20th shift clock -> table all invalid, bist_correct=1.

Source files
------------

// File: rtl/mbist_repair_mux.sv
// MBIST/functional memory port mux with a small address-repair table.
// Optional repair-table scan chain enabled by defining MBIST_REPAIR_SCAN_EN.
module mbist_repair_mux #(
    parameter int                      BIST_ADDR_WD           = 9,
    parameter int                      BIST_DATA_WD           = 32,
    parameter int                      BIST_REPAIR_CNT        = 4,
    parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1F8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bist_en,
    input  logic [BIST_ADDR_WD-1:0]   bist_addr,
    input  logic [BIST_DATA_WD-1:0]   bist_wdata,
    input  logic                      bist_wr,
    input  logic                      bist_rd,
    input  logic                      bist_error,
    input  logic [BIST_ADDR_WD-1:0]   bist_error_addr,
    output logic                      bist_correct,
    output logic                      bist_repair_full,
    input  logic                      bist_shift,
    input  logic                      bist_sdi,
    output logic                      bist_sdo,
    input  logic                      func_cen,
    input  logic                      func_web,
    input  logic [BIST_DATA_WD/8-1:0] func_mask,
    input  logic [BIST_ADDR_WD-1:0]   func_addr,
    input  logic [BIST_DATA_WD-1:0]   func_din,
    output logic [BIST_DATA_WD-1:0]   func_dout,
    output logic                      mem_cen,
    output logic                      mem_web,
    output logic [BIST_DATA_WD/8-1:0] mem_mask,
    output logic [BIST_ADDR_WD-1:0]   mem_addr,
    output logic [BIST_DATA_WD-1:0]   mem_din,
    input  logic [BIST_DATA_WD-1:0]   mem_dout
);

    logic [BIST_REPAIR_CNT-1:0] ent_valid;
    logic [BIST_ADDR_WD-1:0]    ent_addr [BIST_REPAIR_CNT];
    logic [BIST_REPAIR_CNT-1:0] nxt_valid;
    logic [BIST_ADDR_WD-1:0]    nxt_addr [BIST_REPAIR_CNT];
    logic                       nxt_correct;
    logic [BIST_REPAIR_CNT-1:0] free_oh;
    logic                       err_hit;

    logic                       sel_cen;
    logic                       sel_web;
    logic [BIST_DATA_WD/8-1:0]  sel_mask;
    logic [BIST_ADDR_WD-1:0]    sel_addr;
    logic [BIST_DATA_WD-1:0]    sel_din;
    logic [BIST_ADDR_WD-1:0]    remap_addr;
    logic                       remap_hit;

    assign func_dout = mem_dout;

    always_comb begin
        if (bist_en) begin
            sel_cen  = !(bist_rd || bist_wr);
            sel_web  = !bist_wr;
            sel_mask = '1;
            sel_addr = bist_addr;
            sel_din  = bist_wdata;
        end else begin
            sel_cen  = func_cen;
            sel_web  = func_web;
            sel_mask = func_mask;
            sel_addr = func_addr;
            sel_din  = func_din;
        end
    end

    // Lowest matching valid entry wins; uses the table as it stood before this edge.
    always_comb begin
        remap_addr = sel_addr;
        remap_hit  = 1'b0;
        for (int unsigned i = 0; i < BIST_REPAIR_CNT; i++) begin
            if (!remap_hit && ent_valid[i] && ent_addr[i] == sel_addr) begin
                remap_hit  = 1'b1;
                remap_addr = BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(i);
            end
        end
    end

    always_comb begin
        err_hit = 1'b0;
        for (int unsigned i = 0; i < BIST_REPAIR_CNT; i++) begin
            if (ent_valid[i] && ent_addr[i] == bist_error_addr) err_hit = 1'b1;
        end
    end

    // Isolates the lowest clear bit of the valid vector.
    assign free_oh = ~ent_valid & (ent_valid + BIST_REPAIR_CNT'(1));

`ifdef MBIST_REPAIR_SCAN_EN
    logic [BIST_REPAIR_CNT-1:0] shift_in;
    assign shift_in = BIST_REPAIR_CNT'({ent_valid, bist_sdi});
    assign bist_sdo = ent_valid[BIST_REPAIR_CNT-1];
`else
    logic unused_scan;
    assign unused_scan = bist_shift ^ bist_sdi;
    assign bist_sdo    = 1'b0;
`endif

    always_comb begin
        nxt_valid   = ent_valid;
        nxt_addr    = ent_addr;
        nxt_correct = bist_correct;
`ifdef MBIST_REPAIR_SCAN_EN
        if (bist_shift) begin
            for (int unsigned i = 0; i < BIST_REPAIR_CNT; i++) begin
                {nxt_valid[i], nxt_addr[i]} = {ent_addr[i], shift_in[i]};
            end
        end else
`endif
        if (bist_error && !err_hit) begin
            if (|free_oh) begin
                for (int unsigned i = 0; i < BIST_REPAIR_CNT; i++) begin
                    if (free_oh[i]) begin
                        nxt_valid[i] = 1'b1;
                        nxt_addr[i]  = bist_error_addr;
                    end
                end
            end else begin
                nxt_correct = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid        <= '0;
            ent_addr         <= '{default: '0};
            bist_correct     <= 1'b1;
            bist_repair_full <= 1'b0;
            mem_cen          <= 1'b1;
            mem_web          <= 1'b1;
            mem_mask         <= '0;
            mem_addr         <= '0;
            mem_din          <= '0;
        end else begin
            ent_valid        <= nxt_valid;
            ent_addr         <= nxt_addr;
            bist_correct     <= nxt_correct;
            bist_repair_full <= &nxt_valid;
            mem_cen          <= sel_cen;
            mem_web          <= sel_web;
            mem_mask         <= sel_mask;
            mem_addr         <= remap_addr;
            mem_din          <= sel_din;
        end
    end

endmodule
